// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product sequencer: FSM encoding and
// the fixed latency from the last operand transfer to a valid result.
package dp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        CAPT  = 3'd4,
        DONE  = 3'd5
    } dp_state_e;

    localparam int POST_INPUT_LAT = 3;

endpackage

// File: rtl/dot_product_seq.sv
// Sequencer that turns a free-running MAC into a bounded dot-product engine:
// clears the accumulator, streams len operand pairs, captures the sum.
//
// state | meaning
// IDLE  | waiting for start; len captured into the remaining counter
// CLR   | one-cycle accumulator clear pulse, operands held at zero
// RUN   | accepting operand pairs; bubbles feed 0/0 into the MAC
// DRAIN | last pair sits on mac_a/mac_b and is summed at the exit edge
// CAPT  | accumulator is final; latch it into res_data
// DONE  | result presented until res_ready
module dot_product_seq
    import dp_pkg::*;
#(
    parameter int N     = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic [N-1:0]     mac_a,
    output logic [N-1:0]     mac_b,
    output logic             mac_clr,
    input  logic [2*N-1:0]   mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*N-1:0]   res_data,
    output logic             busy
);

    dp_state_e        state, state_nx;
    logic [LEN_W-1:0] remaining;
    logic             xfer;

    assign in_ready = (state == RUN);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CLR;
            CLR:     state_nx = (remaining == '0) ? CAPT : RUN;
            RUN:     if (xfer && remaining == LEN_W'(1)) state_nx = DRAIN;
            DRAIN:   state_nx = CAPT;
            CAPT:    state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are zero on every non-transfer cycle so the free-running MAC holds.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            remaining <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            mac_a   <= xfer ? in_a : '0;
            mac_b   <= xfer ? in_b : '0;
            mac_clr <= (state == IDLE) && start;

            if (state == IDLE && start) begin
                remaining <= len;
            end else if (xfer) begin
                remaining <= remaining - LEN_W'(1);
            end

            if (state == CAPT) begin
                res_data  <= mac_acc;
                res_valid <= 1'b1;
            end else if (state == DONE && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_seq.sv
// Bench for dot_product_seq with a behavioural MAC attached; expected sums
// and latencies come from the job description, not from the DUT.
module tb_dot_product_seq;
    import dp_pkg::*;

    localparam int N     = 32;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             clear;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a, in_b;
    logic [N-1:0]     mac_a, mac_b;
    logic             mac_clr;
    logic [2*N-1:0]   mac_acc = '0;
    logic             res_valid;
    logic             res_ready;
    logic [2*N-1:0]   res_data;
    logic             busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [N-1:0] va [0:15];
    logic [N-1:0] vb [0:15];

    always #5 clk = ~clk;

    dot_product_seq #(.N(N), .LEN_W(LEN_W)) dut (
        .clk(clk), .clear(clear), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    // Free-running MAC with an active-high clear; no reset, so residue survives an abort.
    always @(posedge clk) begin
        if (mac_clr) mac_acc <= '0;
        else         mac_acc <= mac_acc + 64'(mac_a) * 64'(mac_b);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_job(input int n, input int gap_at, input int gap_len,
                           input int rand_gap, input int hold);
        logic [63:0] exp_sum;
        logic [N-1:0] pa, pb;
        logic prev_x, x;
        int idx, cyc, bub, gap_left, clr_cnt, exp_lat;
        exp_sum = '0;
        for (int i = 0; i < n; i++) exp_sum += 64'(va[i]) * 64'(vb[i]);
        pa = '0; pb = '0;

        @(negedge clk);
        start = 1'b1; len = LEN_W'(n); in_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; len = LEN_W'($urandom);
        cyc = 1; idx = 0; bub = 0; gap_left = 0; clr_cnt = 0; prev_x = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));

        while (!res_valid && cyc < 500) begin
            if (mac_clr) clr_cnt++;
            chk("mac_a", 64'(mac_a), prev_x ? 64'(pa) : 64'(0));
            chk("mac_b", 64'(mac_b), prev_x ? 64'(pb) : 64'(0));
            chk("in_ready", 64'(in_ready), 64'(n > 0 && cyc >= 2 && idx < n));
            x = 1'b0;
            res_ready = 1'($urandom_range(0, 1));
            if (idx < n && gap_left == 0) begin
                in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx];
            end else begin
                in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
            end
            if (!in_valid && in_ready) begin
                bub++;
                if (gap_left > 0) gap_left--;
            end
            if (in_valid && in_ready) begin
                x = 1'b1; pa = in_a; pb = in_b; idx++;
                gap_left = ((idx - 1) == gap_at) ? gap_len : 0;
                if (rand_gap > 0) gap_left += $urandom_range(0, rand_gap);
            end
            prev_x = x;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;

        exp_lat = (n == 0) ? 3 : n + 1 + bub + POST_INPUT_LAT;
        chk("res_valid_seen", 64'(res_valid), 64'(1));
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("res_data", res_data, exp_sum);
        chk("clr_pulses", 64'(clr_cnt), 64'(1));
        chk("mac_a_done", 64'(mac_a), 64'(0));
        chk("in_ready_done", 64'(in_ready), 64'(0));

        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            start = 1'($urandom_range(0, 1)); len = LEN_W'($urandom);
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'(1));
            chk("hold_data", res_data, exp_sum);
            chk("hold_busy", 64'(busy), 64'(1));
            chk("hold_clr", 64'(mac_clr), 64'(0));
        end
        start = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("ack_valid", 64'(res_valid), 64'(0));
        chk("ack_busy", 64'(busy), 64'(0));
        chk("ack_data_kept", res_data, exp_sum);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_mac_a"}, 64'(mac_a), 64'(0));
        chk({tag, "_mac_b"}, 64'(mac_b), 64'(0));
        chk({tag, "_mac_clr"}, 64'(mac_clr), 64'(0));
        chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_res_data"}, res_data, 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int k, t;
        clear = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        clear = 1'b1;

        // len=3 back-to-back: 2*3 + 4*5 + 1*7 = 33
        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 1; vb[2] = 7;
        run_job(3, -1, 0, 0, 0);
        chk("job1_sum33", res_data, 64'd33);

        // same job with a two-cycle gap after the first pair
        run_job(3, 0, 2, 0, 0);
        chk("job2_sum33", res_data, 64'd33);

        // empty job, then held result with start pulses ignored
        run_job(0, -1, 0, 0, 5);
        chk("len0_sum", res_data, 64'd0);

        // abort mid-RUN after 2 of 4 pairs
        va[0] = 9; vb[0] = 9; va[1] = 7; vb[1] = 3; va[2] = 5; vb[2] = 5; va[3] = 1; vb[3] = 1;
        @(negedge clk);
        start = 1'b1; len = 4;
        @(negedge clk);
        start = 1'b0;
        k = 0; t = 0;
        while (k < 2 && t < 20) begin
            in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
            if (in_ready) k++;
            @(negedge clk);
            t++;
        end
        chk("abort_pairs_taken", 64'(k), 64'(2));
        in_valid = 1'b0;
        #2 clear = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        clear = 1'b1;
        va[0] = 6; vb[0] = 6;
        run_job(1, -1, 0, 0, 1);
        chk("after_abort_36", res_data, 64'd36);

        // wrap check with all-ones operands
        va[0] = '1; vb[0] = '1; va[1] = '1; vb[1] = '1;
        run_job(2, -1, 0, 0, 0);
        chk("wrap", res_data, 64'hFFFF_FFFC_0000_0002);

        // randomized jobs with random bubbles and result back-pressure
        for (int j = 0; j < 8; j++) begin
            int nl;
            nl = $urandom_range(0, 12);
            for (int i = 0; i < 16; i++) begin
                va[i] = $urandom; vb[i] = $urandom;
            end
            run_job(nl, -1, 0, 2, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
